// File: rtl/ps2_host_send.sv
// Host-to-device PS/2 command transmitter.
// Inhibits the bus, issues a request-to-send, shifts out one byte with odd parity and checks the device acknowledge.
module ps2_host_send #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_low,
    output logic       o_ps2_dat_low,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_timeout
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] START_LAST   = PHASE_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        TX,
        ACK,
        RELEASE
    } stateType;

    stateType          r_state;
    logic              r_clkMeta;
    logic              r_clkSync;
    logic              r_clkPrev;
    logic              r_datMeta;
    logic              r_datSync;
    logic [PHASE_W-1:0] r_phaseCnt;
    logic [TO_W-1:0]   r_timeoutCnt;
    logic [3:0]        r_edgeCnt;
    logic [7:0]        r_data;
    logic              r_parity;
    logic              r_clkLow;
    logic              r_datLow;
    logic              r_done;
    logic              r_ackErr;
    logic              r_timeout;

    stateType          w_stateNext;
    logic [PHASE_W-1:0] w_phaseNext;
    logic [TO_W-1:0]   w_timeoutCntNext;
    logic [3:0]        w_edgeNext;
    logic [7:0]        w_dataNext;
    logic              w_parityNext;
    logic              w_clkLowNext;
    logic              w_datLowNext;
    logic              w_doneNext;
    logic              w_ackErrNext;
    logic              w_timeoutNext;
    logic              w_fall;
    logic              w_expired;

    assign w_fall    = r_clkPrev & ~r_clkSync;
    assign w_expired = ~w_fall && (r_timeoutCnt == TO_LAST);

    // Synchronizers idle high so reset never produces a phantom falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clkMeta    <= 1'b1;
            r_clkSync    <= 1'b1;
            r_clkPrev    <= 1'b1;
            r_datMeta    <= 1'b1;
            r_datSync    <= 1'b1;
            r_state      <= IDLE;
            r_phaseCnt   <= '0;
            r_timeoutCnt <= '0;
            r_edgeCnt    <= '0;
            r_data       <= '0;
            r_parity     <= 1'b0;
            r_clkLow     <= 1'b0;
            r_datLow     <= 1'b0;
            r_done       <= 1'b0;
            r_ackErr     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_clkMeta    <= i_ps2_clk;
            r_clkSync    <= r_clkMeta;
            r_clkPrev    <= r_clkSync;
            r_datMeta    <= i_ps2_dat;
            r_datSync    <= r_datMeta;
            r_state      <= w_stateNext;
            r_phaseCnt   <= w_phaseNext;
            r_timeoutCnt <= w_timeoutCntNext;
            r_edgeCnt    <= w_edgeNext;
            r_data       <= w_dataNext;
            r_parity     <= w_parityNext;
            r_clkLow     <= w_clkLowNext;
            r_datLow     <= w_datLowNext;
            r_done       <= w_doneNext;
            r_ackErr     <= w_ackErrNext;
            r_timeout    <= w_timeoutNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_phaseNext      = r_phaseCnt;
        w_timeoutCntNext = r_timeoutCnt;
        w_edgeNext       = r_edgeCnt;
        w_dataNext       = r_data;
        w_parityNext     = r_parity;
        w_clkLowNext     = r_clkLow;
        w_datLowNext     = r_datLow;
        w_doneNext       = 1'b0;
        w_ackErrNext     = r_ackErr;
        w_timeoutNext    = r_timeout;

        unique case (r_state)
            IDLE: begin
                w_clkLowNext = 1'b0;
                w_datLowNext = 1'b0;
                if (i_valid && o_ready) begin
                    w_dataNext    = i_data;
                    w_parityNext  = ~^i_data;
                    w_ackErrNext  = 1'b0;
                    w_timeoutNext = 1'b0;
                    w_phaseNext   = '0;
                    w_clkLowNext  = 1'b1;
                    w_stateNext   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_phaseCnt == INHIBIT_LAST) begin
                    w_phaseNext  = '0;
                    w_datLowNext = 1'b1;
                    w_stateNext  = START;
                end else begin
                    w_phaseNext = r_phaseCnt + PHASE_W'(1);
                end
            end
            START: begin
                if (r_phaseCnt == START_LAST) begin
                    w_phaseNext      = '0;
                    w_clkLowNext     = 1'b0;
                    w_edgeNext       = '0;
                    w_timeoutCntNext = '0;
                    w_stateNext      = TX;
                end else begin
                    w_phaseNext = r_phaseCnt + PHASE_W'(1);
                end
            end
            TX: begin
                if (w_fall) begin
                    w_timeoutCntNext = '0;
                    w_edgeNext       = r_edgeCnt + 4'd1;
                    // Edge count before increment doubles as the LSB-first bit index.
                    if (r_edgeCnt <= 4'd7) begin
                        w_datLowNext = ~r_data[r_edgeCnt[2:0]];
                    end else if (r_edgeCnt == 4'd8) begin
                        w_datLowNext = ~r_parity;
                    end else begin
                        w_datLowNext = 1'b0;
                        w_stateNext  = ACK;
                    end
                end else if (!w_expired) begin
                    w_timeoutCntNext = r_timeoutCnt + TO_W'(1);
                end
            end
            ACK: begin
                if (w_fall) begin
                    w_timeoutCntNext = '0;
                    w_ackErrNext     = r_datSync;
                    w_stateNext      = RELEASE;
                end else if (!w_expired) begin
                    w_timeoutCntNext = r_timeoutCnt + TO_W'(1);
                end
            end
            RELEASE: begin
                if (r_clkSync && r_datSync) begin
                    w_doneNext  = 1'b1;
                    w_stateNext = IDLE;
                end else if (w_fall) begin
                    w_timeoutCntNext = '0;
                end else if (!w_expired) begin
                    w_timeoutCntNext = r_timeoutCnt + TO_W'(1);
                end
            end
            default: begin
                w_clkLowNext = 1'b0;
                w_datLowNext = 1'b0;
                w_stateNext  = IDLE;
            end
        endcase

        // A silent device aborts the transfer from any of the device-clocked states.
        if ((r_state == TX || r_state == ACK || (r_state == RELEASE && !(r_clkSync && r_datSync)))
            && w_expired) begin
            w_clkLowNext     = 1'b0;
            w_datLowNext     = 1'b0;
            w_doneNext       = 1'b1;
            w_ackErrNext     = 1'b0;
            w_timeoutNext    = 1'b1;
            w_timeoutCntNext = '0;
            w_stateNext      = IDLE;
        end
    end

    assign o_ready       = (r_state == IDLE) && !r_done;
    assign o_busy        = (r_state != IDLE);
    assign o_ps2_clk_low = r_clkLow;
    assign o_ps2_dat_low = r_datLow;
    assign o_done        = r_done;
    assign o_ack_err     = r_ackErr;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_ps2_host_send.sv
// Testbench for ps2_host_send: models an open-drain PS/2 device and compares captured frames
// against an arithmetic reference of the frame format.
module tb_ps2_host_send;

    localparam int INHIBIT = 20;
    localparam int START   = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       iValid;
    logic [7:0] iData;
    logic       oReady;
    logic       oClkLow;
    logic       oDatLow;
    logic       oBusy;
    logic       oDone;
    logic       oAckErr;
    logic       oTimeout;
    logic       devClkLow;
    logic       devDatLow;
    logic       ps2Clk;
    logic       ps2Dat;

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;
    bit holdValid  = 1'b0;

    // Wired-AND bus: either side may pull a line low.
    assign ps2Clk = ~(oClkLow | devClkLow);
    assign ps2Dat = ~(oDatLow | devDatLow);

    ps2_host_send #(
        .INHIBIT_CYCLES(INHIBIT),
        .START_CYCLES  (START),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_valid      (iValid),
        .i_data       (iData),
        .o_ready      (oReady),
        .i_ps2_clk    (ps2Clk),
        .i_ps2_dat    (ps2Dat),
        .o_ps2_clk_low(oClkLow),
        .o_ps2_dat_low(oDatLow),
        .o_busy       (oBusy),
        .o_done       (oDone),
        .o_ack_err    (oAckErr),
        .o_timeout    (oTimeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (oDone) doneCount <= doneCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Frame seen by the device: data LSB first, odd parity, stop bit high.
    function automatic logic [9:0] expectedFrame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Every wait advances on the falling clock edge; jitters i_data while a held-valid test runs.
    task automatic tick();
        @(negedge clock);
        if (holdValid) iData = 8'($urandom);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic acceptAndMeasure(input logic [7:0] byteIn, input bit hold, output int inhibitLen, output int startLen);
        int k;
        k = 0;
        while (!oReady && k < 2000) begin
            tick();
            k++;
        end
        checkOutput("ready_before_send", oReady, 1);
        iData     = byteIn;
        iValid    = 1'b1;
        holdValid = hold;
        tick();
        if (!hold) iValid = 1'b0;
        inhibitLen = 0;
        while (oClkLow && !oDatLow && inhibitLen < 1000) begin
            inhibitLen++;
            tick();
        end
        startLen = 0;
        while (oClkLow && oDatLow && startLen < 1000) begin
            startLen++;
            tick();
        end
    endtask

    // Full device-side transfer; abortMid asserts reset after the 5th device clock fall.
    task automatic applyStimulus(input logic [7:0] byteIn, input bit devAck, input bit hold, input bit abortMid);
        int inhibitLen;
        int startLen;
        int k;
        int donesBefore;
        logic [9:0] seen;
        donesBefore = doneCount;
        acceptAndMeasure(byteIn, hold, inhibitLen, startLen);
        checkOutput("inhibit_cycles", inhibitLen, INHIBIT);
        checkOutput("start_cycles", startLen, START);
        checkOutput("start_bit_line", ps2Dat, 0);
        checkOutput("tx_clk_released", oClkLow, 0);
        checkOutput("busy_in_tx", oBusy, 1);
        seen = '0;
        waitCycles(HALF);
        for (int i = 1; i <= 11; i++) begin
            devClkLow = 1'b1;
            if (abortMid && i == 5) begin
                waitCycles(4);
                donesBefore = doneCount;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkOutput("rst_ready", oReady, 1);
                checkOutput("rst_clk_low", oClkLow, 0);
                checkOutput("rst_dat_low", oDatLow, 0);
                checkOutput("rst_busy", oBusy, 0);
                checkOutput("rst_done", oDone, 0);
                devClkLow = 1'b0;
                devDatLow = 1'b0;
                waitCycles(30);
                checkOutput("no_done_after_reset", doneCount - donesBefore, 0);
                iValid    = 1'b0;
                holdValid = 1'b0;
                return;
            end
            waitCycles(HALF);
            devClkLow = 1'b0;
            if (i <= 10) seen[i-1] = ps2Dat;
            if (i == 10 && devAck) devDatLow = 1'b1;
            if (i == 11) devDatLow = 1'b0;
            if (i < 11) waitCycles(HALF);
        end
        k = 0;
        while (!oDone && k < 500) begin
            tick();
            k++;
        end
        iValid    = 1'b0;
        holdValid = 1'b0;
        checkOutput("done_seen", oDone, 1);
        checkOutput("frame", seen, expectedFrame(byteIn));
        checkOutput("ack_err", oAckErr, !devAck);
        checkOutput("timeout_flag", oTimeout, 0);
        checkOutput("ready_with_done", oReady, 0);
        tick();
        checkOutput("done_one_cycle", oDone, 0);
        checkOutput("ready_after_done", oReady, 1);
        checkOutput("done_count", doneCount - donesBefore, 1);
        waitCycles(3);
        checkOutput("flags_hold", {oAckErr, oTimeout}, {!devAck, 1'b0});
        checkOutput("idle_after", oBusy, 0);
    endtask

    // Device never clocks: the block must give up a fixed time after entering TX.
    task automatic applyTimeout(input logic [7:0] byteIn);
        int inhibitLen;
        int startLen;
        int k;
        acceptAndMeasure(byteIn, 1'b0, inhibitLen, startLen);
        checkOutput("to_inhibit_cycles", inhibitLen, INHIBIT);
        checkOutput("to_start_cycles", startLen, START);
        k = 0;
        while (!oDone && k < 1000) begin
            tick();
            k++;
        end
        checkOutput("timeout_latency", k, TIMEOUT);
        checkOutput("timeout_flag_set", oTimeout, 1);
        checkOutput("timeout_ack_err", oAckErr, 0);
        checkOutput("timeout_clk_low", oClkLow, 0);
        checkOutput("timeout_dat_low", oDatLow, 0);
        waitCycles(2);
        checkOutput("timeout_ready", oReady, 1);
        checkOutput("timeout_flag_hold", oTimeout, 1);
    endtask

    initial begin
        reset     = 1'b1;
        iValid    = 1'b0;
        iData     = 8'h00;
        devClkLow = 1'b0;
        devDatLow = 1'b0;
        waitCycles(3);
        checkOutput("reset_ready", oReady, 1);
        checkOutput("reset_busy", oBusy, 0);
        checkOutput("reset_lines", {oClkLow, oDatLow}, 2'b00);
        checkOutput("reset_flags", {oDone, oAckErr, oTimeout}, 3'b000);
        reset = 1'b0;
        waitCycles(3);

        $display("[TB] send 0xED with ack");
        applyStimulus(8'hED, 1'b1, 1'b0, 1'b0);
        $display("[TB] send 0x01 with ack");
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
        $display("[TB] send 0xA5 without ack");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
        $display("[TB] timeout with silent device");
        applyTimeout(8'h5A);
        $display("[TB] reset mid-transfer then send 0xFF");
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        $display("[TB] held valid with changing data");
        applyStimulus(8'h96, 1'b1, 1'b1, 1'b0);
        $display("[TB] randomized transfers");
        for (int t = 0; t < 8; t++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
